// File: rtl/gemm_tile_engine.sv
// rtl/gemm_tile_engine.sv - NxN tile engine OUT = alpha*A*B + beta*C, row-streamed in and out
// Define GEMM_TILE_SAT_EN to saturate results to DATA_W; otherwise results wrap modulo 2^DATA_W.
module gemm_tile_engine #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int COEF_W = 2
) (
    input  logic                  ref_clk,
    input  logic                  rst_n,
    input  logic [N*DATA_W-1:0]   a_in,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [N*DATA_W-1:0]   b_in,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [N*DATA_W-1:0]   c_in,
    input  logic                  c_valid,
    output logic                  c_ready,
    input  logic [COEF_W-1:0]     alpha,
    input  logic [COEF_W-1:0]     beta,
    output logic [N*DATA_W-1:0]   out,
    output logic [$clog2(N)-1:0]  out_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);
    localparam int IW    = $clog2(N);
    localparam int CW    = $clog2(N + 1);
    localparam int ACC_W = 2 * DATA_W + IW + COEF_W + 1;
    // Wrapping results only depend on the low DATA_W bits, so that build keeps a narrow datapath.
`ifdef GEMM_TILE_SAT_EN
    localparam int CALC_W = ACC_W;
`else
    localparam int CALC_W = DATA_W;
`endif

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_t;
    state_t r_state, w_next;

    logic [CW-1:0]     r_a_cnt, r_b_cnt, r_c_cnt;
    logic [IW-1:0]     r_i, r_k, r_row;
    logic [COEF_W-1:0] r_alpha, r_beta;
    logic [DATA_W-1:0] r_a [N][N];
    logic [DATA_W-1:0] r_b [N][N];
    logic [DATA_W-1:0] r_c [N][N];
    logic [DATA_W-1:0] r_res [N][N];
    logic [CALC_W-1:0] r_acc [N];
    logic [CALC_W-1:0] w_prod [N];
    logic [CALC_W-1:0] w_sum [N];
    logic [CALC_W-1:0] w_full [N];
    logic [DATA_W-1:0] w_red [N];

    logic w_a_fire, w_b_fire, w_c_fire, w_a_done, w_b_done, w_c_done;
    logic w_load_done, w_step_last, w_out_fire, w_drain_last;

    assign w_a_fire     = a_valid && a_ready;
    assign w_b_fire     = b_valid && b_ready;
    assign w_c_fire     = c_valid && c_ready;
    assign w_a_done     = (r_a_cnt == CW'(N)) || (w_a_fire && r_a_cnt == CW'(N - 1));
    assign w_b_done     = (r_b_cnt == CW'(N)) || (w_b_fire && r_b_cnt == CW'(N - 1));
    assign w_c_done     = (r_c_cnt == CW'(N)) || (w_c_fire && r_c_cnt == CW'(N - 1));
    assign w_load_done  = (r_state == S_LOAD) && w_a_done && w_b_done && w_c_done;
    assign w_step_last  = (r_i == IW'(N - 1)) && (r_k == IW'(N - 1));
    assign w_out_fire   = out_valid && out_ready;
    assign w_drain_last = w_out_fire && (r_row == IW'(N - 1));

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_LOAD;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        c_ready   = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_LOAD: begin
                a_ready = (r_a_cnt != CW'(N));
                b_ready = (r_b_cnt != CW'(N));
                c_ready = (r_c_cnt != CW'(N));
                if (w_load_done) w_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (w_step_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (w_drain_last) w_next = S_LOAD;
            end
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_cnt <= '0;
            r_b_cnt <= '0;
            r_c_cnt <= '0;
            r_i     <= '0;
            r_k     <= '0;
            r_row   <= '0;
            r_alpha <= '0;
            r_beta  <= '0;
        end else begin
            if (w_a_fire) r_a_cnt <= r_a_cnt + CW'(1);
            if (w_b_fire) r_b_cnt <= r_b_cnt + CW'(1);
            if (w_c_fire) r_c_cnt <= r_c_cnt + CW'(1);
            if (w_load_done) begin
                r_alpha <= alpha;
                r_beta  <= beta;
                r_i     <= '0;
                r_k     <= '0;
            end
            if (r_state == S_COMPUTE) begin
                if (r_k == IW'(N - 1)) begin
                    r_k <= '0;
                    r_i <= (r_i == IW'(N - 1)) ? '0 : r_i + IW'(1);
                end else begin
                    r_k <= r_k + IW'(1);
                end
            end
            if (w_out_fire) begin
                if (w_drain_last) begin
                    r_row   <= '0;
                    r_a_cnt <= '0;
                    r_b_cnt <= '0;
                    r_c_cnt <= '0;
                end else begin
                    r_row <= r_row + IW'(1);
                end
            end
        end
    end

    // Lane j accumulates A[i][k]*B[k][j]; scaling and C are folded in on the final k step.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_prod[j] = CALC_W'(r_a[r_i][r_k]) * CALC_W'(r_b[r_k][j]);
            w_sum[j]  = (r_k == '0) ? w_prod[j] : r_acc[j] + w_prod[j];
            w_full[j] = CALC_W'(r_alpha) * w_sum[j] + CALC_W'(r_beta) * CALC_W'(r_c[r_i][j]);
`ifdef GEMM_TILE_SAT_EN
            w_red[j]  = (|w_full[j][ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : w_full[j][DATA_W-1:0];
`else
            w_red[j]  = w_full[j];
`endif
        end
    end

    always_ff @(posedge ref_clk) begin
        for (int j = 0; j < N; j++) begin
            if (w_a_fire) r_a[r_a_cnt[IW-1:0]][j] <= a_in[DATA_W*j +: DATA_W];
            if (w_b_fire) r_b[r_b_cnt[IW-1:0]][j] <= b_in[DATA_W*j +: DATA_W];
            if (w_c_fire) r_c[r_c_cnt[IW-1:0]][j] <= c_in[DATA_W*j +: DATA_W];
            if (r_state == S_COMPUTE) begin
                r_acc[j] <= w_sum[j];
                if (r_k == IW'(N - 1)) r_res[r_i][j] <= w_red[j];
            end
        end
    end

    always_comb begin
        out = '0;
        if (r_state == S_DRAIN) begin
            for (int j = 0; j < N; j++) out[DATA_W*j +: DATA_W] = r_res[r_row][j];
        end
    end

    assign out_row = r_row;
endmodule
